// File: rtl/loader_pkg.sv
// Shared types and framing constants for the boot-time image loader.
package loader_pkg;

   typedef enum logic [2:0] {HDR, DATA, CHK, RUN, ERR} loader_state_t;

   localparam int HDR_BYTES      = 4;
   localparam int BYTES_PER_WORD = 4;

endpackage

// File: rtl/byte_packer.sv
// Little-endian byte-to-word packer; word_valid pulses the cycle after the 4th byte.
// clear drops any partial word and suppresses a pending pulse.
module byte_packer (
   input  logic        clk,
   input  logic        rst,
   input  logic        in_valid,
   input  logic [7:0]  in_byte,
   input  logic        clear,
   output logic        word_valid,
   output logic [31:0] word
);

   logic [1:0] idx;

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         idx        <= 2'd0;
         word       <= 32'd0;
         word_valid <= 1'b0;
      end else if (clear) begin
         idx        <= 2'd0;
         word       <= 32'd0;
         word_valid <= 1'b0;
      end else begin
         word_valid <= in_valid && (idx == 2'd3);
         if (in_valid) begin
            word[{idx, 3'b000} +: 8] <= in_byte;
            idx                      <= idx + 2'd1;
         end
      end
   end

endmodule

// File: rtl/imem_loader.sv
// Boot loader: header/payload/checksum byte stream -> imem word writes, core held in reset until valid.
// One write pulse the cycle after each word's 4th byte; s_ready drops only in RUN/ERR.
module imem_loader #(
   parameter logic [31:0] BASE_ADDR = 32'hBFC0_0000,
   parameter int unsigned MAX_WORDS = 1024
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        s_valid,
   output logic        s_ready,
   input  logic [7:0]  s_data,
   input  logic        reload,
   output logic        mem_we,
   output logic [31:0] mem_addr,
   output logic [31:0] mem_wdata,
   output logic        cpu_rst,
   output logic        done,
   output logic        err
);
   import loader_pkg::*;

   loader_state_t state;
   logic [1:0]    byte_cnt;
   logic [31:0]   n_words;
   logic [31:0]   word_idx;
   logic [7:0]    csum;

   logic          accept, hdr_last, word_last, rearm;
   logic          pk_in_vld, pk_clear, pk_vld;
   logic [31:0]   pk_dat, hdr_count;
   logic [7:0]    chk_sum;

   assign s_ready   = (state == HDR) || (state == DATA) || (state == CHK);
   assign accept    = s_valid && s_ready;
   assign hdr_last  = accept && (state == HDR)  && (byte_cnt == 2'(HDR_BYTES - 1));
   assign word_last = accept && (state == DATA) && (byte_cnt == 2'(BYTES_PER_WORD - 1));
   assign rearm     = reload && ((state == RUN) || (state == ERR));
   // The header count is taken straight off the packer plus the in-flight top byte,
   // and the packer is cleared so the header never shows up as a memory write.
   assign hdr_count = {s_data, pk_dat[23:0]};
   assign chk_sum   = csum + s_data;
   assign pk_in_vld = accept && ((state == HDR) || (state == DATA));
   assign pk_clear  = hdr_last || rearm;

   byte_packer u_packer (
      .clk        (clk),
      .rst        (rst),
      .in_valid   (pk_in_vld),
      .in_byte    (s_data),
      .clear      (pk_clear),
      .word_valid (pk_vld),
      .word       (pk_dat)
   );

   assign mem_we    = pk_vld;
   assign mem_wdata = pk_dat;

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state    <= HDR;
         cpu_rst  <= 1'b1;
         done     <= 1'b0;
         err      <= 1'b0;
         byte_cnt <= 2'd0;
         n_words  <= 32'd0;
         word_idx <= 32'd0;
         csum     <= 8'd0;
         mem_addr <= BASE_ADDR;
      end else begin
         if (pk_in_vld) byte_cnt <= byte_cnt + 2'd1;
         // Address advances after each pulse, so the last word's pulse in CHK still lands correctly.
         if (mem_we) mem_addr <= mem_addr + 32'd4;
         case (state)
            HDR: begin
               if (hdr_last) begin
                  n_words  <= hdr_count;
                  word_idx <= 32'd0;
                  csum     <= 8'd0;
                  mem_addr <= BASE_ADDR;
                  if ((hdr_count == 32'd0) || (hdr_count > MAX_WORDS)) begin
                     state <= ERR;
                     err   <= 1'b1;
                  end else begin
                     state <= DATA;
                  end
               end
            end
            DATA: begin
               if (accept) begin
                  csum <= chk_sum;
                  if (word_last) begin
                     word_idx <= word_idx + 32'd1;
                     if (word_idx == n_words - 32'd1) state <= CHK;
                  end
               end
            end
            CHK: begin
               if (accept) begin
                  if (chk_sum == 8'd0) begin
                     state   <= RUN;
                     cpu_rst <= 1'b0;
                     done    <= 1'b1;
                  end else begin
                     state <= ERR;
                     err   <= 1'b1;
                  end
               end
            end
            RUN, ERR: begin
               if (reload) begin
                  state    <= HDR;
                  cpu_rst  <= 1'b1;
                  done     <= 1'b0;
                  err      <= 1'b0;
                  byte_cnt <= 2'd0;
                  n_words  <= 32'd0;
                  word_idx <= 32'd0;
                  csum     <= 8'd0;
                  mem_addr <= BASE_ADDR;
               end
            end
            default: state <= HDR;
         endcase
      end
   end

endmodule

// File: tb/tb_imem_loader.sv
// Bench for imem_loader: stream-level reference model compared every cycle, plus literal image checks.
module tb_imem_loader;

   localparam logic [31:0] BASE = 32'hBFC0_0000;
   localparam int          MAXW = 1024;

   logic        clk = 1'b0;
   logic        rst = 1'b0;
   logic        s_valid = 1'b0;
   logic [7:0]  s_data = 8'd0;
   logic        reload = 1'b0;
   logic        s_ready, mem_we, cpu_rst, done, err;
   logic [31:0] mem_addr, mem_wdata;

   always #5 clk = ~clk;

   imem_loader #(.BASE_ADDR(BASE), .MAX_WORDS(MAXW)) dut (
      .clk       (clk),
      .rst       (rst),
      .s_valid   (s_valid),
      .s_ready   (s_ready),
      .s_data    (s_data),
      .reload    (reload),
      .mem_we    (mem_we),
      .mem_addr  (mem_addr),
      .mem_wdata (mem_wdata),
      .cpu_rst   (cpu_rst),
      .done      (done),
      .err       (err)
   );

   int n_cmp = 0;
   int n_bad = 0;

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %h, expected %h (t=%0t)", nm, act, exp, $time);
      end
   endtask

   // Reference model: everything is derived from the bytes accepted since the last (re)start.
   int          nb;
   logic [31:0] m_n;
   logic [7:0]  m_sum;
   logic [7:0]  m_cur [4];
   logic        m_pulse;
   logic [31:0] m_paddr, m_pdata;

   function automatic bit hdr_bad();
      return (nb >= 4) && ((m_n == 0) || (m_n > MAXW));
   endfunction
   function automatic bit img_end();
      return !hdr_bad() && (nb >= 4) && (nb == 5 + 4 * int'(m_n));
   endfunction
   function automatic bit exp_run();
      return img_end() && (m_sum == 8'd0);
   endfunction
   function automatic bit exp_err();
      return hdr_bad() || (img_end() && (m_sum != 8'd0));
   endfunction
   function automatic bit exp_rdy();
      return !(exp_run() || exp_err());
   endfunction

   always @(posedge clk or negedge rst) begin
      if (!rst) begin
         nb = 0; m_n = 0; m_sum = 0; m_pulse = 0;
      end else begin
         bit rdy;
         rdy = exp_rdy();
         m_pulse = 1'b0;
         if (reload && !rdy) begin
            nb = 0; m_n = 0; m_sum = 0;
         end else if (s_valid && rdy) begin
            if (nb < 4) begin
               m_n[8*nb +: 8] = s_data;
            end else begin
               m_sum = m_sum + s_data;
               if (nb < 4 + 4 * int'(m_n)) begin
                  m_cur[(nb - 4) % 4] = s_data;
                  if ((nb - 4) % 4 == 3) begin
                     m_pulse = 1'b1;
                     m_paddr = BASE + 32'(4 * ((nb - 4) / 4));
                     m_pdata = {m_cur[3], m_cur[2], m_cur[1], m_cur[0]};
                  end
               end
            end
            nb++;
         end
      end
   end

   logic [31:0] wr_addr_q[$];
   logic [31:0] wr_data_q[$];

   always @(negedge clk) begin
      if (mem_we) begin
         wr_addr_q.push_back(mem_addr);
         wr_data_q.push_back(mem_wdata);
      end
      if (!rst) begin
         chk("rst_s_ready", s_ready, 1);
         chk("rst_cpu_rst", cpu_rst, 1);
         chk("rst_mem_we", mem_we, 0);
         chk("rst_mem_addr", mem_addr, BASE);
         chk("rst_mem_wdata", mem_wdata, 0);
         chk("rst_done", done, 0);
         chk("rst_err", err, 0);
      end else begin
         chk("s_ready", s_ready, exp_rdy());
         chk("cpu_rst", cpu_rst, !exp_run());
         chk("done", done, exp_run());
         chk("err", err, exp_err());
         chk("mem_we", mem_we, m_pulse);
         if (m_pulse) begin
            chk("mem_addr", mem_addr, m_paddr);
            chk("mem_wdata", mem_wdata, m_pdata);
         end
      end
   end

   // Stimulus
   logic [7:0] img[$];
   logic [7:0] s1_img [13] = '{8'h02, 8'h00, 8'h00, 8'h00, 8'h93, 8'h00, 8'h50, 8'h00,
                              8'h13, 8'h01, 8'hA0, 8'h00, 8'h69};

   task automatic tick();
      @(posedge clk);
      #2;
   endtask

   task automatic send(input logic [7:0] b, input bit stall, input bit rl);
      int t;
      if (stall) begin
         repeat ($urandom_range(0, 2)) begin
            s_valid = 1'b0;
            s_data  = 8'($urandom);
            reload  = rl ? 1'($urandom_range(0, 1)) : 1'b0;
            tick();
         end
      end
      reload  = 1'b0;
      s_valid = 1'b1;
      s_data  = b;
      t = 0;
      forever begin
         bit got;
         got = s_ready;
         tick();
         if (got) break;
         t++;
         if (t > 20) begin
            n_cmp++; n_bad++;
            $display("FAIL send_timeout: s_ready stayed 0, expected 1 within 20 cycles");
            break;
         end
      end
      s_valid = 1'b0;
      s_data  = 8'($urandom);
   endtask

   task automatic send_img(input bit stall, input bit rl);
      foreach (img[i]) send(img[i], stall, rl);
   endtask

   task automatic mk_s1(input logic [7:0] cs);
      img.delete();
      foreach (s1_img[i]) img.push_back(s1_img[i]);
      img[12] = cs;
   endtask

   task automatic mk_image(input logic [31:0] n, input bit bad);
      logic [7:0] sum, b;
      sum = 8'd0;
      img.delete();
      for (int i = 0; i < 4; i++) img.push_back(n[8*i +: 8]);
      if ((n != 0) && (n <= MAXW)) begin
         for (int i = 0; i < 4 * int'(n); i++) begin
            b = 8'($urandom);
            img.push_back(b);
            sum = sum + b;
         end
         b = 8'd0 - sum;
         if (bad) b = b + 8'd1;
         img.push_back(b);
      end
   endtask

   task automatic do_reload();
      s_valid = 1'b0;
      reload  = 1'b1;
      tick();
      reload  = 1'b0;
      chk("reload_s_ready", s_ready, 1);
      chk("reload_cpu_rst", cpu_rst, 1);
   endtask

   task automatic clear_log();
      wr_addr_q.delete();
      wr_data_q.delete();
   endtask

   task automatic check_s1_log(input string tag);
      chk({tag, "_nwr"}, wr_addr_q.size(), 2);
      chk({tag, "_addr0"}, wr_addr_q[0], 32'hBFC0_0000);
      chk({tag, "_data0"}, wr_data_q[0], 32'h0050_0093);
      chk({tag, "_addr1"}, wr_addr_q[1], 32'hBFC0_0004);
      chk({tag, "_data1"}, wr_data_q[1], 32'h00A0_0113);
      chk({tag, "_done"}, done, 1);
      chk({tag, "_cpu_rst"}, cpu_rst, 0);
   endtask

   initial begin
      repeat (3) tick();
      rst = 1'b1;
      tick();

      // Good two-word image
      clear_log();
      mk_s1(8'h69);
      send_img(1'b0, 1'b0);
      tick(); tick();
      check_s1_log("s1");
      s_valid = 1'b1;
      repeat (3) begin s_data = 8'($urandom); tick(); end
      do_reload();

      // Same image, bad checksum; stream must not be consumed while in ERR
      mk_s1(8'h6A);
      send_img(1'b0, 1'b0);
      tick();
      chk("s2_err", err, 1);
      chk("s2_cpu_rst", cpu_rst, 1);
      chk("s2_s_ready", s_ready, 0);
      s_valid = 1'b1;
      repeat (3) begin s_data = 8'($urandom); tick(); end
      do_reload();

      // Zero-length header
      clear_log();
      mk_image(32'd0, 1'b0);
      send_img(1'b0, 1'b0);
      tick(); tick();
      chk("s3_err", err, 1);
      chk("s3_nwr", wr_addr_q.size(), 0);
      do_reload();

      // Oversized header, then maximum size image
      mk_image(32'd1025, 1'b0);
      send_img(1'b0, 1'b0);
      tick();
      chk("s4_err", err, 1);
      do_reload();
      clear_log();
      mk_image(32'd1024, 1'b0);
      send_img(1'b0, 1'b0);
      tick(); tick();
      chk("s4_done", done, 1);
      chk("s4_nwr", wr_addr_q.size(), 1024);
      chk("s4_last_addr", wr_addr_q[$], 32'hBFC0_0FFC);
      do_reload();

      // Random stalls and ignored reload pulses mid-load
      clear_log();
      mk_s1(8'h69);
      send_img(1'b1, 1'b1);
      tick(); tick();
      check_s1_log("s5");
      do_reload();
      repeat (3) begin
         mk_image(32'($urandom_range(1, 6)), 1'($urandom_range(0, 1)));
         send_img(1'b1, 1'b1);
         tick();
         do_reload();
      end

      // Async reset in the middle of the payload, then a clean load
      mk_s1(8'h69);
      for (int i = 0; i < 5; i++) send(img[i], 1'b0, 1'b0);
      rst = 1'b0;
      repeat (3) tick();
      rst = 1'b1;
      tick();
      clear_log();
      send_img(1'b0, 1'b0);
      tick(); tick();
      check_s1_log("s6");

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
